// File: rtl/spi_sclk_engine.sv
// spi_sclk_engine: SPI SCLK generator with bit count, CPOL/CPHA modes, hold phase and done pulse
// Optional stall input i_pause is present only when SPI_SCLK_PAUSE_EN is defined.
module spi_sclk_engine #(
  parameter int DIV_W = 16,
  parameter int LEN_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic [DIV_W-1:0] i_divider,
  input  logic [LEN_W-1:0] i_num_bits,
`ifdef SPI_SCLK_PAUSE_EN
  input  logic             i_pause,
`endif
  output logic             o_sclk,
  output logic             o_pos_edge,
  output logic             o_neg_edge,
  output logic             o_sample,
  output logic             o_shift,
  output logic             o_busy,
  output logic             o_done
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t             r_state;
  logic [DIV_W-1:0]   r_cnt;
  logic [DIV_W-1:0]   r_div;
  logic [LEN_W:0]     r_n;
  logic [LEN_W+1:0]   r_edge;
  logic               r_cpha;
  logic               w_run;
  logic               w_wrap;
  logic               w_last;
  logic               w_lead;
`ifdef SPI_SCLK_PAUSE_EN
  assign w_run = ~i_pause;
`else
  assign w_run = 1'b1;
`endif
  assign w_wrap = r_cnt == r_div;
  // r_edge holds edges already produced, so the upcoming edge is r_edge+1
  assign w_last = r_edge == {r_n, 1'b0} - (LEN_W+2)'(1);
  assign w_lead = ~r_edge[0];
  // Transfer FSM: counts half-periods, toggles SCLK on wrap, issues strobes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_div      <= '0;
      r_n        <= '0;
      r_edge     <= '0;
      r_cpha     <= 1'b0;
      o_sclk     <= 1'b0;
      o_pos_edge <= 1'b0;
      o_neg_edge <= 1'b0;
      o_sample   <= 1'b0;
      o_shift    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_pos_edge <= 1'b0;
      o_neg_edge <= 1'b0;
      o_sample   <= 1'b0;
      o_shift    <= 1'b0;
      o_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          o_sclk <= i_cpol;
          if (i_start) begin
            r_div   <= i_divider;
            r_n     <= {i_num_bits == '0, i_num_bits};
            r_cpha  <= i_cpha;
            r_cnt   <= '0;
            r_edge  <= '0;
            o_busy  <= 1'b1;
            o_shift <= ~i_cpha;
            r_state <= RUN;
          end
        end
        RUN: if (w_run) begin
          if (w_wrap) begin
            r_cnt      <= '0;
            r_edge     <= r_edge + (LEN_W+2)'(1);
            o_sclk     <= ~o_sclk;
            o_pos_edge <= ~o_sclk;
            o_neg_edge <= o_sclk;
            o_sample   <= r_cpha ? ~w_lead : w_lead;
            o_shift    <= r_cpha ? w_lead : ~w_lead & ~w_last;
            if (w_last) r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        HOLD: if (w_run) begin
          if (w_wrap) begin
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_sclk_engine.sv
// tb_spi_sclk_engine: directed-vector bench for spi_sclk_engine
module tb_spi_sclk_engine;
  logic        clk = 1'b0;
  logic        rst, start, cpol, cpha, pz;
  logic [15:0] div;
  logic [5:0]  nbits;
  logic        sclk, pos_e, neg_e, smp, shf, busy, done;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  spi_sclk_engine #(.DIV_W(16), .LEN_W(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cpol(cpol), .i_cpha(cpha),
    .i_divider(div), .i_num_bits(nbits),
`ifdef SPI_SCLK_PAUSE_EN
    .i_pause(pz),
`endif
    .o_sclk(sclk), .o_pos_edge(pos_e), .o_neg_edge(neg_e), .o_sample(smp),
    .o_shift(shf), .o_busy(busy), .o_done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One transfer, observed at every negedge; cycle 1 is the first busy cycle
  task automatic run_xfer(input string nm, input bit pol, input bit pha, input int d, input int nb,
                          input int mid, input bit pre, input bit b2b, input int pz_edge);
    int n, exp_busy, budget, nbusy, edges, first, last, flagbad, gapbad, sbad;
    int nsmp, nshf, srise, dcyc, pz_end;
    bit prev, tog, fshift;
    n = (nb == 0) ? 64 : nb;
    exp_busy = (2*n+1)*(d+1) + (pz_edge > 0 ? 10 : 0);
    budget = exp_busy + 20;
    {nbusy, edges, first, last, flagbad, gapbad, sbad, nsmp, nshf, srise, dcyc, pz_end} = '0;
    fshift = 1'b0;
    cpol = pol; cpha = pha; div = 16'(d); nbits = 6'(nb);
    if (!pre) begin
      @(negedge clk);
      @(negedge clk);
      chk({nm, "_idle_lvl"}, sclk, pol);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    if (pre) chk({nm, "_b2b_busy"}, busy, 1);
    prev = pol;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == mid) begin start = 1'b1; div = 16'(d+3); nbits = 6'(nb+1); end
      if (cyc == mid + 1) start = 1'b0;
      if (cyc == pz_end) pz = 1'b0;
      if (busy) nbusy++;
      tog = sclk != prev;
      if ((pos_e != (sclk && !prev)) || (neg_e != (!sclk && prev))) flagbad++;
      if (tog) begin
        if (edges == 0) first = cyc;
        else if (cyc - last != d + 1 + (edges == pz_edge ? 10 : 0)) gapbad++;
        last = cyc;
        edges++;
        if (edges == pz_edge) begin pz = 1'b1; pz_end = cyc + 10; end
      end
      if (smp) begin nsmp++; if (pos_e) srise++; if (!tog) sbad++; end
      if (shf) begin nshf++; if (!tog && cyc != 1) sbad++; end
      if (cyc == 1) fshift = shf;
      prev = sclk;
      if (done) begin dcyc = cyc; break; end
    end
    div = 16'(d); nbits = 6'(nb);
    chk({nm, "_busy_len"}, nbusy, exp_busy);
    chk({nm, "_done_cyc"}, dcyc, exp_busy + 1);
    chk({nm, "_edges"}, edges, 2*n);
    chk({nm, "_first_edge"}, first, d + 2);
    chk({nm, "_gap_err"}, gapbad, 0);
    chk({nm, "_flag_err"}, flagbad, 0);
    chk({nm, "_samples"}, nsmp, n);
    chk({nm, "_shifts"}, nshf, n);
    chk({nm, "_samp_rise"}, srise, (pol == pha) ? n : 0);
    chk({nm, "_strobe_err"}, sbad, 0);
    chk({nm, "_first_shift"}, fshift, !pha);
    if (b2b) start = 1'b1;
    else begin
      @(negedge clk);
      chk({nm, "_after"}, {busy, done, sclk}, {2'b00, pol});
    end
  endtask

  initial begin
    int edges, cnt;
    bit prev;
    rst = 1'b1; start = 1'b0; cpol = 1'b1; cpha = 1'b0; pz = 1'b0; div = 16'd0; nbits = 6'd8;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", {sclk, pos_e, neg_e, smp, shf, busy, done}, 0);
    rst = 1'b0;
    run_xfer("t1_m0_d0", 0, 0, 0, 8, 0, 0, 0, 0);
    run_xfer("t2_m3_d3", 1, 1, 3, 4, 0, 0, 0, 0);
    run_xfer("t3_n0_d1", 0, 0, 1, 0, 0, 0, 0, 0);
    run_xfer("m2_d2", 1, 0, 2, 3, 0, 0, 0, 0);
    run_xfer("m1_n1", 0, 1, 0, 1, 0, 0, 0, 0);
    run_xfer("t4_mid", 0, 1, 2, 5, 7, 0, 1, 0);
    run_xfer("t4_b2b", 0, 1, 2, 5, 0, 1, 0, 0);
`ifdef SPI_SCLK_PAUSE_EN
    run_xfer("t6_pause", 0, 0, 2, 4, 0, 0, 0, 3);
`endif
    // Reset at edge 5 of an N=8, CPOL=1 transfer
    cpol = 1'b1; cpha = 1'b0; div = 16'd1; nbits = 6'd8;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    prev = 1'b1;
    for (int c = 0; c < 100 && edges < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (sclk != prev) edges++;
      prev = sclk;
    end
    chk("t5_reached_e5", edges, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_outs", {sclk, pos_e, neg_e, smp, shf, busy, done}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle_cpol", sclk, 1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("t5_no_done", cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
